param_fifo: RTL

//  Parametrised synchronous FIFO; next generation of the fixed 32x4 FIFO. Adds

---
 rtl/param_fifo_if.sv | 33 +++
 rtl/param_fifo.sv | 113 +++++++++++
 2 files changed

// File: rtl/param_fifo_if.sv
// Producer/consumer bundle for param_fifo: active-low strobes, thresholds and status.
// The FIFO connects through the slave modport; the driving side uses master.
interface param_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             FClrN;
  logic             FInN;
  logic             FOutN;
  logic [WIDTH-1:0] Data_In;
  logic [CW-1:0]    AF_Thresh;
  logic [CW-1:0]    AE_Thresh;
  logic [WIDTH-1:0] F_Data;
  logic             F_FullN;
  logic             F_EmptyN;
  logic             F_AFullN;
  logic             F_AEmptyN;
  logic [CW-1:0]    F_Count;
  logic             F_OvfN;
  logic             F_UdfN;

  modport master (
    output FClrN, FInN, FOutN, Data_In, AF_Thresh, AE_Thresh,
    input  F_Data, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN, F_Count, F_OvfN, F_UdfN
  );

  modport slave (
    input  FClrN, FInN, FOutN, Data_In, AF_Thresh, AE_Thresh,
    output F_Data, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN, F_Count, F_OvfN, F_UdfN
  );
endinterface

// File: rtl/param_fifo.sv
// Parametrised show-ahead synchronous FIFO with run-time almost-full/empty
// thresholds, exact occupancy and sticky overflow/underflow flags.
module param_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic         Clk,
  input  logic         RstN,
  param_fifo_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full_n;
  logic             r_empty_n;
  logic             r_afull_n;
  logic             r_aempty_n;
  logic             r_ovf_n;
  logic             r_udf_n;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_full_n_nxt;
  logic             w_empty_n_nxt;
  logic             w_afull_n_nxt;
  logic             w_aempty_n_nxt;

  // A write into a full FIFO is still taken when a read frees the head slot.
  assign w_rd_acc  = ~bus.FOutN & r_empty_n;
  assign w_wr_acc  = ~bus.FInN & (r_full_n | w_rd_acc);
  assign w_ovf_evt = ~bus.FInN & ~r_full_n & ~w_rd_acc;
  assign w_udf_evt = ~bus.FOutN & ~r_empty_n;

  // Next occupancy and status flags, so flags move on the same edge as the count.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    w_full_n_nxt   = (w_count_nxt != CW'(DEPTH));
    w_empty_n_nxt  = (w_count_nxt != CW'(0));
    w_afull_n_nxt  = ~(w_count_nxt >= bus.AF_Thresh);
    w_aempty_n_nxt = ~(w_count_nxt <= bus.AE_Thresh);
  end

  // Pointers, occupancy and registered flags; clear takes priority over strobes.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_wr_ptr   <= PW'(0);
      r_rd_ptr   <= PW'(0);
      r_count    <= CW'(0);
      r_full_n   <= 1'b1;
      r_empty_n  <= 1'b0;
      r_afull_n  <= 1'b1;
      r_aempty_n <= 1'b0;
      r_ovf_n    <= 1'b1;
      r_udf_n    <= 1'b1;
    end else if (!bus.FClrN) begin
      r_wr_ptr   <= PW'(0);
      r_rd_ptr   <= PW'(0);
      r_count    <= CW'(0);
      r_full_n   <= 1'b1;
      r_empty_n  <= 1'b0;
      r_afull_n  <= 1'b1;
      r_aempty_n <= 1'b0;
      r_ovf_n    <= 1'b1;
      r_udf_n    <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? PW'(0) : r_wr_ptr + PW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? PW'(0) : r_rd_ptr + PW'(1);
      end
      r_count    <= w_count_nxt;
      r_full_n   <= w_full_n_nxt;
      r_empty_n  <= w_empty_n_nxt;
      r_afull_n  <= w_afull_n_nxt;
      r_aempty_n <= w_aempty_n_nxt;
      if (w_ovf_evt) begin
        r_ovf_n <= 1'b0;
      end
      if (w_udf_evt) begin
        r_udf_n <= 1'b0;
      end
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge Clk) begin
    if (bus.FClrN && w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.Data_In;
    end
  end

  assign bus.F_Data    = r_mem[r_rd_ptr];
  assign bus.F_FullN   = r_full_n;
  assign bus.F_EmptyN  = r_empty_n;
  assign bus.F_AFullN  = r_afull_n;
  assign bus.F_AEmptyN = r_aempty_n;
  assign bus.F_Count   = r_count;
  assign bus.F_OvfN    = r_ovf_n;
  assign bus.F_UdfN    = r_udf_n;
endmodule
